// File: rtl/alu_cmd_driver.sv
// Purpose  : queues ALU operand commands, issues them one at a time to the ALU and returns each result.
// Latency  : push at edge t -> pop at t+1, alu_valid during t+1..t+2, res_valid the edge after alu_ready.
// Backpres.: cmd_ready = !full (a same-cycle pop does not help); a held result (res_ready=0) stalls the queue.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_mode/a/b  upstream command (opcode 0..10 legal, 32-bit operands)
//   alu_valid, alu_mode, alu_in_A/B    one-cycle issue pulse and operands held until the result returns
//   alu_ready, alu_out_data            ALU result strobe and 64-bit result
//   res_valid/res_ready, res_data/err  result port; res_err marks an illegal opcode (or a timeout)
//   busy                               queue non-empty or a command in progress
//
// Optional macro ALU_DRV_TIMEOUT_EN: bounds the wait for alu_ready to TIMEOUT_CYCLES cycles.
module alu_cmd_driver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_mode,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        alu_valid,
  output logic [3:0]  alu_mode,
  output logic [31:0] alu_in_A,
  output logic [31:0] alu_in_B,
  input  logic        alu_ready,
  input  logic [63:0] alu_out_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_err,
  output logic        busy
);

  localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  MAX_MODE = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  logic [3:0]    mode_mem [FIFO_DEPTH];
  logic [31:0]   a_mem    [FIFO_DEPTH];
  logic [31:0]   b_mem    [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, push, pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  // Storage carries no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mode_mem[wr_ptr] <= cmd_mode;
      a_mem[wr_ptr]    <= cmd_a;
      b_mem[wr_ptr]    <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // FIFO_DEPTH is a power of two, so pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic cap_alu;   // load res_data from the ALU, clear res_err
  logic set_err;   // load res_data=0, res_err=1
`ifdef ALU_DRV_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  logic        clr_cnt, inc_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap_alu   = 1'b0;
    set_err   = 1'b0;
    alu_valid = 1'b0;
    res_valid = 1'b0;
`ifdef ALU_DRV_TIMEOUT_EN
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // Illegal opcodes are answered locally; the ALU never sees them.
          if (mode_mem[rd_ptr] > MAX_MODE) begin
            set_err   = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        alu_valid = 1'b1;
        // A zero-latency ALU answers in the issue cycle itself.
        if (alu_ready) begin
          cap_alu   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_WAIT;
`ifdef ALU_DRV_TIMEOUT_EN
          clr_cnt   = 1'b1;
`endif
        end
      end
      S_WAIT: begin
        // alu_ready is tested first so it wins over a coincident timeout.
        if (alu_ready) begin
          cap_alu   = 1'b1;
          state_nxt = S_RESP;
        end
`ifdef ALU_DRV_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          set_err   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          inc_cnt = 1'b1;
        end
`endif
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef ALU_DRV_TIMEOUT_EN
  // Counts completed WAIT cycles; reaching TMO_LAST means the current
  // cycle is the TIMEOUT_CYCLES-th one spent waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tmo_cnt <= '0;
    else if (clr_cnt) tmo_cnt <= '0;
    else if (inc_cnt) tmo_cnt <= tmo_cnt + 16'd1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Operand and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_mode <= '0;
      alu_in_A <= '0;
      alu_in_B <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      // Operands load only on pop, so they stay stable through ISSUE/WAIT/RESP.
      if (pop) begin
        alu_mode <= mode_mem[rd_ptr];
        alu_in_A <= a_mem[rd_ptr];
        alu_in_B <= b_mem[rd_ptr];
      end
      if (cap_alu) begin
        res_data <= alu_out_data;
        res_err  <= 1'b0;
      end else if (set_err) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end
    end
  end

  assign busy = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Purpose : self-checking bench for alu_cmd_driver with a behavioural ALU and a result queue model.
// Ports   : drives every DUT port; all activity happens on the falling clock edge.
// Macro   : ALU_DRV_TIMEOUT_EN selects the timeout scenario instead of the unlimited-wait one.
module tb_alu_cmd_driver;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_mode;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        alu_valid;
  logic [3:0]  alu_mode;
  logic [31:0] alu_in_A;
  logic [31:0] alu_in_B;
  logic        alu_ready;
  logic [63:0] alu_out_data;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  alu_cmd_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_valid    (alu_valid),
    .alu_mode     (alu_mode),
    .alu_in_A     (alu_in_A),
    .alu_in_B     (alu_in_B),
    .alu_ready    (alu_ready),
    .alu_out_data (alu_out_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_err      (res_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: what it computes is irrelevant to the driver, it only
  // has to be deterministic so the model can predict the pass-through value.
  function automatic logic [63:0] alu_fn(input logic [3:0] m, input logic [31:0] a,
                                         input logic [31:0] b);
    case (m)
      4'd0:    return {32'd0, a} + {32'd0, b};
      4'd9:    return {32'd0, a} * {32'd0, b};
      default: return {b, a} ^ {60'd0, m};
    endcase
  endfunction

  // Expected results in acceptance order: {err, data}.
  logic [64:0] exp_q[$];

  task automatic model_push(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    if (m > 4'd10) exp_q.push_back({1'b1, 64'd0});
    else           exp_q.push_back({1'b0, alu_fn(m, a, b)});
  endtask

  // ALU responder: answers each issue pulse alu_delay cycles later
  // (0 = in the issue cycle, negative = never). Aborts on reset.
  int alu_delay   = 1;
  int valid_pulses = 0;
  initial begin
    alu_ready    = 1'b0;
    alu_out_data = 64'd0;
    forever begin
      @(negedge clk);
      if (rst_n && alu_valid) begin
        int d;
        logic [63:0] r;
        d = alu_delay;
        valid_pulses++;
        r = alu_fn(alu_mode, alu_in_A, alu_in_B);
        if (d >= 0) begin
          for (int i = 0; i < d && rst_n; i++) @(negedge clk);
          if (rst_n) begin
            alu_ready    = 1'b1;
            alu_out_data = r;
            @(negedge clk);
            alu_ready    = 1'b0;
            alu_out_data = {$urandom, $urandom};
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the push.
  task automatic push_one(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!cmd_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_a     = a;
    cmd_b     = b;
    if (cmd_ready) model_push(m, a, b);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits for the next result, compares it with the model and accepts it.
  task automatic get_one(input string tag);
    int w;
    logic [64:0] e;
    w = 0;
    while (!res_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_res_valid"}, res_valid, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
    chk({tag, "_res_data"}, res_data, e[63:0]);
    chk({tag, "_res_err"}, res_err, e[64]);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    int p0;
    int w;
    logic        ok;
    logic [31:0] ha, hb;
    logic [3:0]  hm;
    int          pushed;
    logic [64:0] e;

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 4'd0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    res_ready = 1'b0;

    // ---------------- reset state ----------------
    #3 rst_n = 1'b0;
    #1;
    chk("rst_alu_valid", alu_valid, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_data", res_data, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);

    // ---------------- add 5+7, ALU answers one cycle after issue ----------------
    alu_delay = 1;
    p0 = valid_pulses;
    cmd_valid = 1'b1; cmd_mode = 4'd0; cmd_a = 32'd5; cmd_b = 32'd7;
    model_push(4'd0, 32'd5, 32'd7);
    @(negedge clk);                       // after push edge t
    cmd_valid = 1'b0;
    chk("t2_valid_t", alu_valid, 1'b0);
    chk("t2_busy_t", busy, 1'b1);
    @(negedge clk);                       // after t+1: issue cycle
    chk("t2_valid_t1", alu_valid, 1'b1);
    chk("t2_in_A", alu_in_A, 32'd5);
    chk("t2_in_B", alu_in_B, 32'd7);
    chk("t2_mode", alu_mode, 4'd0);
    @(negedge clk);                       // wait cycle, ALU strobes now
    chk("t2_valid_t2", alu_valid, 1'b0);
    chk("t2_res_early", res_valid, 1'b0);
    @(negedge clk);
    chk("t2_res_valid", res_valid, 1'b1);
    chk("t2_res_12", res_data, 64'd12);
    get_one("t2");
    chk("t2_pulses", valid_pulses - p0, 1);

    // ---------------- multiply, 33-cycle ALU latency ----------------
    alu_delay = 33;
    push_one(4'd9, 32'hFFFF_FFFF, 32'd2);
    w = 0;
    while (!alu_valid && w < 20) begin @(negedge clk); w++; end
    chk("t3_issue", alu_valid, 1'b1);
    hm = alu_mode; ha = alu_in_A; hb = alu_in_B;
    ok = 1'b1;
    w  = 0;
    while (!res_valid && w < 200) begin
      @(negedge clk);
      w++;
      if (!res_valid && (alu_valid || alu_in_A !== ha || alu_in_B !== hb || alu_mode !== hm))
        ok = 1'b0;
    end
    chk("t3_stable", ok, 1'b1);
    chk("t3_latency", w, 34);
    chk("t3_res", res_data, 64'h1_FFFF_FFFE);
    // A stray strobe while the result is held must not disturb it.
    alu_ready = 1'b1; alu_out_data = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    alu_ready = 1'b0;
    @(negedge clk);
    chk("t3_stray_data", res_data, 64'h1_FFFF_FFFE);
    chk("t3_stray_vld", res_valid, 1'b1);
    get_one("t3");

    // ---------------- illegal opcode ----------------
    alu_delay = 0;
    p0 = valid_pulses;
    push_one(4'hC, 32'h1234_5678, 32'h9ABC_DEF0);
    get_one("t5");
    chk("t5_no_issue", valid_pulses - p0, 0);

    // ---------------- fill the queue while the result is held ----------------
    alu_delay = 2;
    for (int i = 0; i < 5; i++) push_one(4'(i + 1), $urandom, $urandom);
    chk("t4_full", cmd_ready, 1'b0);
    chk("t4_busy", busy, 1'b1);
    cmd_valid = 1'b1; cmd_mode = 4'd3; cmd_a = 32'hAAAA; cmd_b = 32'h5555;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready) ok = 1'b0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("t4_held_full", ok, 1'b1);
    for (int i = 0; i < 5; i++) get_one("t4_drain");
    chk("t4_empty_model", exp_q.size(), 0);

    // ---------------- reset in the middle of a wait ----------------
    alu_delay = 50;
    push_one(4'd1, 32'd11, 32'd22);
    push_one(4'd2, 32'd33, 32'd44);
    push_one(4'd3, 32'd55, 32'd66);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t1_alu_valid", alu_valid, 1'b0);
    chk("t1_alu_mode", alu_mode, 4'd0);
    chk("t1_alu_in_A", alu_in_A, 32'd0);
    chk("t1_alu_in_B", alu_in_B, 32'd0);
    chk("t1_res_valid", res_valid, 1'b0);
    chk("t1_res_data", res_data, 64'd0);
    chk("t1_res_err", res_err, 1'b0);
    chk("t1_busy", busy, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_rel_busy", busy, 1'b0);
    chk("t1_rel_ready", cmd_ready, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (res_valid || alu_valid) ok = 1'b0;
      @(negedge clk);
    end
    chk("t1_quiet", ok, 1'b1);

    // ---------------- random traffic against the model ----------------
    pushed = 0;
    w = 0;
    while ((pushed < 40 || exp_q.size() > 0) && w < 4000) begin
      alu_delay = $urandom_range(0, 4);
      if (pushed < 40) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_mode  = 4'($urandom_range(0, 15));
        cmd_a     = $urandom;
        cmd_b     = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end
      res_ready = 1'($urandom_range(0, 1));
      if (cmd_valid && cmd_ready) begin
        model_push(cmd_mode, cmd_a, cmd_b);
        pushed++;
      end
      if (res_valid && res_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
        chk("rnd_data", res_data, e[63:0]);
        chk("rnd_err", res_err, e[64]);
      end
      @(negedge clk);
      w++;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    chk("rnd_done", exp_q.size(), 0);
    chk("rnd_pushed", pushed, 40);
    repeat (4) @(negedge clk);
    chk("rnd_idle", busy, 1'b0);

`ifdef ALU_DRV_TIMEOUT_EN
    // ---------------- ALU never answers: timeout after 64 wait cycles ----------------
    alu_delay = -1;
    push_one(4'd5, 32'h77, 32'h88);
    w = 0;
    while (!alu_valid && w < 20) begin @(negedge clk); w++; end
    chk("t6_issue", alu_valid, 1'b1);
    w = 0;
    while (!res_valid && w < 300) begin @(negedge clk); w++; end
    chk("t6_wait_cycles", w - 1, 64);
    chk("t6_err", res_err, 1'b1);
    chk("t6_data", res_data, 64'd0);
    alu_ready = 1'b1; alu_out_data = 64'h1234;
    @(negedge clk);
    alu_ready = 1'b0;
    @(negedge clk);
    chk("t6_late_err", res_err, 1'b1);
    chk("t6_late_data", res_data, 64'd0);
    exp_q.delete();
    exp_q.push_back({1'b1, 64'd0});
    get_one("t6");
`else
    // ---------------- without the timeout the wait is unlimited ----------------
    alu_delay = 100;
    push_one(4'd5, 32'h77, 32'h88);
    get_one("t6_long_wait");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
